// File: rtl/i2c_pkg.sv
// Shared I2C definitions: receiver state encoding and bus field widths.
package i2c_pkg;

    localparam int I2C_BYTE_W = 8;
    localparam int I2C_ADDR_W = 7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_DATA0,
        ST_ACK_D0,
        ST_DATA1,
        ST_ACK_D1,
        ST_WAIT_STOP,
        ST_IGNORE
    } i2c_rx_state_t;

    // True while our address has been ACKed but the frame is not yet complete.
    function automatic logic is_acked(i2c_rx_state_t s);
        return s inside {ST_ACK_A, ST_DATA0, ST_ACK_D0, ST_DATA1, ST_ACK_D1};
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer for one open-drain bus line, with previous-value register
// and rise/fall decode. Resets to 1 (the idle bus level) so reset release
// on an idle bus produces no spurious edges. SYNC_STAGES must be >= 2.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw line through the synchronizer and keep the last level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: receives START, address+W, two data bytes, STOP,
// ACKs its own address, and presents the frame with a one-cycle strobe.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_ADDR_W-1:0] rx_addr,
    output logic [I2C_BYTE_W-1:0] rx_data0,
    output logic [I2C_BYTE_W-1:0] rx_data1,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst(rst), .din(scl_in),
        .level(scl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst(rst), .din(sda_in),
        .level(sda), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = scl & sda_fall;
    assign stop_det  = scl & sda_rise;

    i2c_rx_state_t           state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    // Set after the 8th SCL rise of a byte, or after the SCL rise of an ACK bit;
    // the next SCL fall then completes that phase.
    logic                    full_q, full_d;
    logic [I2C_BYTE_W-1:0]   shreg_q, shreg_d;
    logic [I2C_ADDR_W-1:0]   addr_q, addr_d;
    logic [I2C_BYTE_W-1:0]   hold0_q, hold0_d;
    logic [I2C_BYTE_W-1:0]   hold1_q, hold1_d;
    logic                    sda_oe_q, sda_oe_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic [I2C_ADDR_W-1:0]   rx_addr_q;
    logic [I2C_BYTE_W-1:0]   rx_data0_q, rx_data1_q;

    // State and datapath registers; reset releases SDA immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            shreg_q    <= '0;
            addr_q     <= '0;
            hold0_q    <= '0;
            hold1_q    <= '0;
            sda_oe_q   <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rx_addr_q  <= '0;
            rx_data0_q <= '0;
            rx_data1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            shreg_q  <= shreg_d;
            addr_q   <= addr_d;
            hold0_q  <= hold0_d;
            hold1_q  <= hold1_d;
            sda_oe_q <= sda_oe_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            if (valid_d) begin
                rx_addr_q  <= addr_q;
                rx_data0_q <= hold0_q;
                rx_data1_q <= hold1_q;
            end
        end
    end

    // Next-state: bus conditions first, then per-state SCL edge handling.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        full_d   = full_q;
        shreg_d  = shreg_q;
        addr_d   = addr_q;
        hold0_d  = hold0_q;
        hold1_d  = hold1_q;
        sda_oe_d = sda_oe_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        busy_d   = busy_q;

        if (start_det) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            full_d   = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
            err_d    = is_acked(state_q);
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            full_d   = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            valid_d  = (state_q == ST_WAIT_STOP);
            err_d    = is_acked(state_q);
        end else begin
            case (state_q)
                ST_ADDR, ST_DATA0, ST_DATA1: begin
                    if (scl_rise && !full_q) begin
                        shreg_d = {shreg_q[I2C_BYTE_W-2:0], sda};
                        cnt_d   = cnt_q + 3'd1;
                        full_d  = (cnt_q == 3'd7);
                    end else if (scl_fall && full_q) begin
                        full_d = 1'b0;
                        cnt_d  = '0;
                        if (state_q == ST_ADDR) begin
                            if (shreg_q[7:1] == SLAVE_ADDR && !shreg_q[0]) begin
                                state_d  = ST_ACK_A;
                                sda_oe_d = 1'b1;
                                addr_d   = shreg_q[7:1];
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else if (state_q == ST_DATA0) begin
                            state_d  = ST_ACK_D0;
                            sda_oe_d = 1'b1;
                            hold0_d  = shreg_q;
                        end else begin
                            state_d  = ST_ACK_D1;
                            sda_oe_d = 1'b1;
                            hold1_d  = shreg_q;
                        end
                    end
                end
                ST_ACK_A, ST_ACK_D0, ST_ACK_D1: begin
                    if (scl_rise) begin
                        full_d = 1'b1;
                    end else if (scl_fall && full_q) begin
                        full_d   = 1'b0;
                        sda_oe_d = 1'b0;
                        state_d  = (state_q == ST_ACK_A)  ? ST_DATA0 :
                                   (state_q == ST_ACK_D0) ? ST_DATA1 : ST_WAIT_STOP;
                    end
                end
                // The master's STOP itself raises SCL once before SDA rises, so
                // one rise is tolerated; a following fall means an extra bit.
                ST_WAIT_STOP: begin
                    if (scl_rise) begin
                        full_d = 1'b1;
                    end else if (scl_fall && full_q) begin
                        full_d  = 1'b0;
                        state_d = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe      = sda_oe_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign busy        = busy_q;
    assign rx_addr     = rx_addr_q;
    assign rx_data0    = rx_data0_q;
    assign rx_data1    = rx_data1_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a behavioural I2C master drives the bus
// (open-drain wired-AND with the target's sda_oe) and each task checks its scenario.
module tb_i2c_slave_rx;

    localparam int Q = 10;  // clocks per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_in;
    logic       m_sda;
    logic       sda_in;
    logic       sda_oe;
    logic [6:0] rx_addr;
    logic [7:0] rx_data0, rx_data1;
    logic       frame_valid, frame_err, busy;

    int checks = 0;
    int errors = 0;

    int nvalid_tot = 0;
    int nerr_tot   = 0;
    int both_tot   = 0;
    int oe_tot     = 0;

    assign sda_in = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .rx_addr(rx_addr), .rx_data0(rx_data0),
        .rx_data1(rx_data1), .frame_valid(frame_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always @(negedge clk) begin
        if (frame_valid) nvalid_tot++;
        if (frame_err) nerr_tot++;
        if (frame_valid && frame_err) both_tot++;
        if (sda_oe) oe_tot++;
    end

    task automatic qwait(input int n = 1);
        repeat (n * Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; qwait();
        scl_in = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        scl_in = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; qwait();
        scl_in = 1'b1; qwait();
        m_sda = 1'b1; qwait(2);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; qwait();
            scl_in = 1'b1; qwait(2);
            scl_in = 1'b0; qwait();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        m_sda = 1'b1; qwait();
        scl_in = 1'b1; qwait();
        ack = sda_oe;
        qwait();
        scl_in = 1'b0; qwait();
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                              output logic [2:0] acks);
        bus_start();
        send_byte(a, acks[2]);
        send_byte(d0, acks[1]);
        send_byte(d1, acks[0]);
        bus_stop();
    endtask

    task automatic test_reset();
        rst = 1'b1; scl_in = 1'b1; m_sda = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        qwait();
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (rx_addr !== 7'h00) begin errors++; $display("FAIL reset_rx_addr: got %h expected 00", rx_addr); end
        checks++; if (rx_data0 !== 8'h00 || rx_data1 !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h %h expected 00 00", rx_data0, rx_data1); end
        checks++; if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b %b expected 0 0", frame_valid, frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_nominal();
        int v0, e0;
        logic a;
        v0 = nvalid_tot; e0 = nerr_tot;
        bus_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nominal_busy_high: got %b expected 1", busy); end
        send_byte(8'hA0, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL nominal_ack_addr: got %b expected 1", a); end
        send_byte(8'hA5, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL nominal_ack_d0: got %b expected 1", a); end
        send_byte(8'h3C, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL nominal_ack_d1: got %b expected 1", a); end
        checks++; if (nvalid_tot - v0 !== 0) begin errors++; $display("FAIL nominal_early_valid: got %0d expected 0", nvalid_tot - v0); end
        bus_stop();
        checks++; if (nvalid_tot - v0 !== 1) begin errors++; $display("FAIL nominal_valid_count: got %0d expected 1", nvalid_tot - v0); end
        checks++; if (nerr_tot - e0 !== 0) begin errors++; $display("FAIL nominal_err_count: got %0d expected 0", nerr_tot - e0); end
        checks++; if (rx_addr !== 7'h50) begin errors++; $display("FAIL nominal_rx_addr: got %h expected 50", rx_addr); end
        checks++; if (rx_data0 !== 8'hA5) begin errors++; $display("FAIL nominal_rx_data0: got %h expected a5", rx_data0); end
        checks++; if (rx_data1 !== 8'h3C) begin errors++; $display("FAIL nominal_rx_data1: got %h expected 3c", rx_data1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_low: got %b expected 0", busy); end
    endtask

    task automatic test_wrong_addr();
        int v0, e0, o0;
        logic [2:0] acks;
        v0 = nvalid_tot; e0 = nerr_tot; o0 = oe_tot;
        send_frame(8'hA2, 8'hDE, 8'hAD, acks);
        checks++; if (acks !== 3'b000) begin errors++; $display("FAIL wrong_addr_acks: got %b expected 000", acks); end
        checks++; if (oe_tot - o0 !== 0) begin errors++; $display("FAIL wrong_addr_oe_cycles: got %0d expected 0", oe_tot - o0); end
        checks++; if (nvalid_tot - v0 !== 0 || nerr_tot - e0 !== 0) begin errors++; $display("FAIL wrong_addr_strobes: got %0d %0d expected 0 0", nvalid_tot - v0, nerr_tot - e0); end
        checks++; if ({rx_addr, rx_data0, rx_data1} !== {7'h50, 8'hA5, 8'h3C}) begin errors++; $display("FAIL wrong_addr_outputs: got %h %h %h expected 50 a5 3c", rx_addr, rx_data0, rx_data1); end
    endtask

    task automatic test_read_bit();
        int v0, e0;
        logic [2:0] acks;
        v0 = nvalid_tot; e0 = nerr_tot;
        send_frame(8'hA1, 8'h77, 8'h88, acks);
        checks++; if (acks !== 3'b000) begin errors++; $display("FAIL read_bit_acks: got %b expected 000", acks); end
        checks++; if (nvalid_tot - v0 !== 0 || nerr_tot - e0 !== 0) begin errors++; $display("FAIL read_bit_strobes: got %0d %0d expected 0 0", nvalid_tot - v0, nerr_tot - e0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_bit_busy: got %b expected 0", busy); end
    endtask

    task automatic test_stop_after_d0();
        int v0, e0;
        logic a0, a1;
        v0 = nvalid_tot; e0 = nerr_tot;
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h11, a1);
        bus_stop();
        checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL stop_d0_acks: got %b expected 11", {a0, a1}); end
        checks++; if (nerr_tot - e0 !== 1) begin errors++; $display("FAIL stop_d0_err_count: got %0d expected 1", nerr_tot - e0); end
        checks++; if (nvalid_tot - v0 !== 0) begin errors++; $display("FAIL stop_d0_valid_count: got %0d expected 0", nvalid_tot - v0); end
        checks++; if (rx_data0 !== 8'hA5) begin errors++; $display("FAIL stop_d0_rx_data0: got %h expected a5", rx_data0); end
    endtask

    task automatic test_repeated_start();
        int v0, e0;
        logic a0, a1;
        logic [2:0] acks;
        v0 = nvalid_tot; e0 = nerr_tot;
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h99, a1);
        send_frame(8'hA0, 8'h01, 8'h02, acks);
        checks++; if ({a0, a1, acks} !== 5'b11111) begin errors++; $display("FAIL rep_start_acks: got %b expected 11111", {a0, a1, acks}); end
        checks++; if (nerr_tot - e0 !== 1) begin errors++; $display("FAIL rep_start_err_count: got %0d expected 1", nerr_tot - e0); end
        checks++; if (nvalid_tot - v0 !== 1) begin errors++; $display("FAIL rep_start_valid_count: got %0d expected 1", nvalid_tot - v0); end
        checks++; if ({rx_data0, rx_data1} !== 16'h0102) begin errors++; $display("FAIL rep_start_rx_data: got %h %h expected 01 02", rx_data0, rx_data1); end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        logic a;
        logic [2:0] acks;
        bus_start();
        send_byte(8'hA0, a);
        send_bits(8'h55);
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_mid_ack_d0_oe: got %b expected 1", sda_oe); end
        #3 rst = 1'b1;
        #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_async_oe: got %b expected 0", sda_oe); end
        checks++; if ({rx_addr, rx_data0, rx_data1} !== 23'h0) begin errors++; $display("FAIL rst_mid_outputs: got %h %h %h expected 00 00 00", rx_addr, rx_data0, rx_data1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_sda = 1'b1; qwait();
        scl_in = 1'b1; qwait();
        v0 = nvalid_tot;
        send_frame(8'hA0, 8'h12, 8'h34, acks);
        checks++; if (acks !== 3'b111) begin errors++; $display("FAIL rst_after_acks: got %b expected 111", acks); end
        checks++; if (nvalid_tot - v0 !== 1) begin errors++; $display("FAIL rst_after_valid_count: got %0d expected 1", nvalid_tot - v0); end
        checks++; if ({rx_addr, rx_data0, rx_data1} !== {7'h50, 8'h12, 8'h34}) begin errors++; $display("FAIL rst_after_outputs: got %h %h %h expected 50 12 34", rx_addr, rx_data0, rx_data1); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wrong_addr();
        test_read_bit();
        test_stop_after_d0();
        test_repeated_start();
        test_reset_mid_frame();
        checks++; if (both_tot !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", both_tot); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
